// File: rtl/scaled_sprite_anim_renderer_pkg.sv
// Shared types and bitmap generator for the scaled sprite animation renderer.
// Contents: rgb332_t, TRANSPARENT_ENCODING, anim_state_t, sprite_pixel().
// Imported by the interface, the frame ROM and the top.
package sprite_pkg;

  typedef logic [7:0] rgb332_t;

  localparam rgb332_t TRANSPARENT_ENCODING = 8'hFF;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    POP   = 2'd1,
    GONE  = 2'd2
  } anim_state_t;

  // Bitmap content. Distances are taken in doubled units so that the centre
  // of an even-sized bitmap lands on a pixel corner. Frame 0 is a solid ball
  // with a bright core; pop frames are rings whose hole grows with the frame.
  function automatic rgb332_t sprite_pixel(int f, int y, int x, int w, int h,
                                           int nf, rgb332_t transp);
    int dx;
    int dy;
    int d2;
    int r2;
    logic [2:0] shade;
    dx    = 2 * x - (w - 1);
    dy    = 2 * y - (h - 1);
    d2    = dx * dx + dy * dy;
    r2    = w * w;
    shade = f[2:0];
    if (d2 > r2) return transp;
    if (f == 0) return (d2 * 4 <= r2) ? 8'hFC : 8'hF0;
    if (d2 * nf >= r2 * f) return {3'd7, shade, 2'b00};
    return transp;
  endfunction

endpackage

// File: rtl/scaled_sprite_anim_renderer_if.sv
// Pixel/control bundle between ball logic, the sprite renderer and the drawing mux.
// master: drives offsets, bracket, visibility, frame strobe and pop/rearm requests.
// slave: the renderer; returns pixel, drawing request and animation status. Macro: SPRITE_TINT_EN.
interface scaled_sprite_anim_renderer_if;
  import sprite_pkg::*;

  logic        startOfFrame;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;
  logic        visible;
  logic        popReq;
  logic        rearm;
`ifdef SPRITE_TINT_EN
  rgb332_t     tintColor;
`endif
  logic        drawingRequest;
  rgb332_t     RGBout;
  logic        popping;
  logic        popDone;

`ifdef SPRITE_TINT_EN
  modport master (output startOfFrame, offsetX, offsetY, InsideRectangle, visible,
                         popReq, rearm, tintColor,
                  input  drawingRequest, RGBout, popping, popDone);
  modport slave  (input  startOfFrame, offsetX, offsetY, InsideRectangle, visible,
                         popReq, rearm, tintColor,
                  output drawingRequest, RGBout, popping, popDone);
`else
  modport master (output startOfFrame, offsetX, offsetY, InsideRectangle, visible,
                         popReq, rearm,
                  input  drawingRequest, RGBout, popping, popDone);
  modport slave  (input  startOfFrame, offsetX, offsetY, InsideRectangle, visible,
                         popReq, rearm,
                  output drawingRequest, RGBout, popping, popDone);
`endif
endinterface

// File: rtl/scaled_sprite_anim_renderer_rom.sv
// Combinational multi-frame sprite bitmap: pix_o = rom[frame_i][sy_i][sx_i].
// Ports: frame_i/sy_i/sx_i table indices (caller keeps them in range), pix_o RGB332 pixel.
// Table is elaborated from sprite_pkg::sprite_pixel, so it folds to constants.
module sprite_frame_rom
  import sprite_pkg::*;
#(
  parameter int      WIDTH_X     = 20,
  parameter int      HEIGHT_Y    = 20,
  parameter int      NUM_FRAMES  = 4,
  parameter rgb332_t TRANSPARENT = TRANSPARENT_ENCODING,
  localparam int     FW = $clog2(NUM_FRAMES),
  localparam int     YW = $clog2(HEIGHT_Y),
  localparam int     XW = $clog2(WIDTH_X)
) (
  input  logic [FW-1:0] frame_i,
  input  logic [YW-1:0] sy_i,
  input  logic [XW-1:0] sx_i,
  output rgb332_t       pix_o
);

  rgb332_t rom [NUM_FRAMES][HEIGHT_Y][WIDTH_X];

  for (genvar f = 0; f < NUM_FRAMES; f++) begin : g_f
    for (genvar y = 0; y < HEIGHT_Y; y++) begin : g_y
      for (genvar x = 0; x < WIDTH_X; x++) begin : g_x
        assign rom[f][y][x] = sprite_pixel(f, y, x, WIDTH_X, HEIGHT_Y,
                                           NUM_FRAMES, TRANSPARENT);
      end
    end
  end

  assign pix_o = rom[frame_i][sy_i][sx_i];

endmodule

// File: rtl/scaled_sprite_anim_renderer.sv
// Scaled ball sprite with pop animation; one registered RGB332 pixel per clk (latency 1).
// Ports: clk, resetN (async, active-low), bus (slave modport: offsets/control in, pixel/status out).
// Optional SPRITE_TINT_EN: opaque pixels drawn during POP are replaced by tintColor.
module scaled_sprite_anim_renderer
  import sprite_pkg::*;
#(
  parameter int      WIDTH_X     = 20,
  parameter int      HEIGHT_Y    = 20,
  parameter int      SCALE_SHIFT = 1,
  parameter int      NUM_FRAMES  = 4,
  parameter int      FRAME_HOLD  = 6,
  parameter rgb332_t TRANSPARENT = TRANSPARENT_ENCODING
) (
  input  logic                          clk,
  input  logic                          resetN,
  scaled_sprite_anim_renderer_if.slave  bus
);

  localparam int FW = $clog2(NUM_FRAMES);
  localparam int YW = $clog2(HEIGHT_Y);
  localparam int XW = $clog2(WIDTH_X);
  localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  anim_state_t   state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          pop_done_q, pop_done_d;
  rgb332_t       rgb_q, rgb_d;

  // ---------------- animation FSM ----------------
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    hold_d     = hold_q;
    pop_done_d = 1'b0;
    if (bus.rearm) begin
      // rearm has priority over popReq in every state
      state_d = ALIVE;
      frame_d = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        ALIVE: begin
          frame_d = '0;
          if (bus.popReq) begin
            state_d = POP;
            frame_d = FW'(1);
            hold_d  = '0;
          end
        end
        POP: begin
          if (bus.startOfFrame) begin
            if (hold_q == HW'(FRAME_HOLD - 1)) begin
              hold_d = '0;
              if (frame_q == FW'(NUM_FRAMES - 1)) begin
                state_d    = GONE;
                pop_done_d = 1'b1;
              end else begin
                frame_d = frame_q + FW'(1);
              end
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
        end
        GONE: ;
        default: state_d = ALIVE;
      endcase
    end
  end

  // ---------------- pixel path ----------------
  logic [10:0]   sx, sy;
  logic          in_range;
  logic [XW-1:0] rom_x;
  logic [YW-1:0] rom_y;
  rgb332_t       rom_pix;

  assign sx       = bus.offsetX >> SCALE_SHIFT;
  assign sy       = bus.offsetY >> SCALE_SHIFT;
  assign in_range = (sx < 11'(WIDTH_X)) && (sy < 11'(HEIGHT_Y));
  // Out-of-range coordinates are forced to 0 so the ROM is never addressed past its edge.
  assign rom_x    = in_range ? sx[XW-1:0] : '0;
  assign rom_y    = in_range ? sy[YW-1:0] : '0;

  sprite_frame_rom #(
    .WIDTH_X     (WIDTH_X),
    .HEIGHT_Y    (HEIGHT_Y),
    .NUM_FRAMES  (NUM_FRAMES),
    .TRANSPARENT (TRANSPARENT)
  ) u_rom (
    .frame_i (frame_q),
    .sy_i    (rom_y),
    .sx_i    (rom_x),
    .pix_o   (rom_pix)
  );

  always_comb begin
    rgb_d = TRANSPARENT;
    if (bus.InsideRectangle && bus.visible && state_q != GONE && in_range) begin
      rgb_d = rom_pix;
`ifdef SPRITE_TINT_EN
      if (state_q == POP && rom_pix != TRANSPARENT) rgb_d = bus.tintColor;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= ALIVE;
      frame_q    <= '0;
      hold_q     <= '0;
      pop_done_q <= 1'b0;
      rgb_q      <= TRANSPARENT;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      hold_q     <= hold_d;
      pop_done_q <= pop_done_d;
      rgb_q      <= rgb_d;
    end
  end

  assign bus.RGBout         = rgb_q;
  assign bus.drawingRequest = (rgb_q != TRANSPARENT);
  assign bus.popping        = (state_q == POP);
  assign bus.popDone        = pop_done_q;

endmodule

// File: tb/tb_scaled_sprite_anim_renderer.sv
// Directed bench for scaled_sprite_anim_renderer with hand-computed pixel values.
// Default parameters (20x20, scale 2, 4 frames, hold 6); SPRITE_TINT_EN aware.
// Inputs driven 1 time unit after the rising edge; outputs sampled at that point.
module tb_scaled_sprite_anim_renderer;
  import sprite_pkg::*;

  logic clk;
  logic resetN;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  scaled_sprite_anim_renderer_if bus ();

  scaled_sprite_anim_renderer dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed bitmap values (doubled-unit distance d2 from centre):
  //  (9,9): d2=2 -> frame0 core FC, pop frames transparent
  //  (x0,y9) and (x19,y9): d2=362 -> frame0 F0, frame1 E4, frame2 E8, frame3 EC
  localparam logic [7:0] C_CORE = 8'hFC;
  localparam logic [7:0] C_RIM  = 8'hF0;
  localparam logic [7:0] C_TR   = 8'hFF;
`ifdef SPRITE_TINT_EN
  localparam logic [7:0] C_F1 = 8'hE0;
  localparam logic [7:0] C_F2 = 8'hE0;
  localparam logic [7:0] C_F3 = 8'hE0;
`else
  localparam logic [7:0] C_F1 = 8'hE4;
  localparam logic [7:0] C_F2 = 8'hE8;
  localparam logic [7:0] C_F3 = 8'hEC;
`endif

  task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int x, input int y);
    bus.offsetX = 11'(x);
    bus.offsetY = 11'(y);
  endtask

  task automatic sof();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    tick();
  endtask

  task automatic pulse_pop();
    bus.popReq = 1'b1;
    tick();
    bus.popReq = 1'b0;
  endtask

  logic pd;
  int   pd_early;
  int   pd_cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN              = 1'b0;
    bus.startOfFrame    = 1'b0;
    bus.InsideRectangle = 1'b1;
    bus.visible         = 1'b1;
    bus.popReq          = 1'b0;
    bus.rearm           = 1'b0;
`ifdef SPRITE_TINT_EN
    bus.tintColor       = 8'hE0;
`endif
    set_px(18, 18);
    repeat (2) tick();
    check_vec("rst_rgb", bus.RGBout, C_TR);
    check_vec("rst_req", 8'(bus.drawingRequest), 8'd0);
    check_vec("rst_popping", 8'(bus.popping), 8'd0);
    check_vec("rst_popdone", 8'(bus.popDone), 8'd0);
    resetN = 1'b1;

    // 1: centre pixel, frame 0
    tick();
    check_vec("t1_rgb", bus.RGBout, C_CORE);
    check_vec("t1_req", 8'(bus.drawingRequest), 8'd1);

    // 2: range and gating
    set_px(40, 0); tick();
    check_vec("t2_sx20_rgb", bus.RGBout, C_TR);
    check_vec("t2_sx20_req", 8'(bus.drawingRequest), 8'd0);
    set_px(18, 18); bus.InsideRectangle = 1'b0; tick();
    check_vec("t2_outside", bus.RGBout, C_TR);
    bus.InsideRectangle = 1'b1; bus.visible = 1'b0; tick();
    check_vec("t2_invisible", bus.RGBout, C_TR);
    bus.visible = 1'b1;
    set_px(39, 18); tick();
    check_vec("t2_sx19_edge", bus.RGBout, C_RIM);
    set_px(18, 40); tick();
    check_vec("t2_sy20", bus.RGBout, C_TR);
    set_px(0, 18); tick();
    check_vec("t2_rim", bus.RGBout, C_RIM);

    // 4a: simultaneous popReq and rearm in ALIVE
    bus.popReq = 1'b1; bus.rearm = 1'b1; tick();
    bus.popReq = 1'b0; bus.rearm = 1'b0;
    check_vec("t4_both_popping", 8'(bus.popping), 8'd0);
    tick();
    check_vec("t4_both_rgb", bus.RGBout, C_RIM);

    // 3 / 6: full pop sequence
    pulse_pop();
    check_vec("t3_popping", 8'(bus.popping), 8'd1);
    tick();
    check_vec("t3_f1_rim", bus.RGBout, C_F1);
    set_px(18, 18); tick();
    check_vec("t3_f1_hole", bus.RGBout, C_TR);
    set_px(0, 18);
    pd_early = 0;
    for (int i = 1; i <= 18; i++) begin
      bus.startOfFrame = 1'b1;
      tick();
      pd = bus.popDone;
      bus.startOfFrame = 1'b0;
      tick();
      if (i < 18 && pd) pd_early++;
      case (i)
        5:  check_vec("t3_sof5_f1", bus.RGBout, C_F1);
        6:  check_vec("t3_sof6_f2", bus.RGBout, C_F2);
        11: check_vec("t3_sof11_f2", bus.RGBout, C_F2);
        12: check_vec("t3_sof12_f3", bus.RGBout, C_F3);
        17: begin
          check_vec("t3_no_early_done", 8'(pd_early), 8'd0);
          check_vec("t3_sof17_popping", 8'(bus.popping), 8'd1);
        end
        18: begin
          check_vec("t3_done_pulse", 8'(pd), 8'd1);
          check_vec("t3_done_one_clk", 8'(bus.popDone), 8'd0);
          check_vec("t3_gone_popping", 8'(bus.popping), 8'd0);
          check_vec("t3_gone_rgb", bus.RGBout, C_TR);
        end
        default: ;
      endcase
    end
    set_px(18, 18); tick();
    check_vec("t3_gone_centre", bus.RGBout, C_TR);
    pulse_pop(); tick();
    check_vec("t3_gone_popreq", bus.RGBout, C_TR);

    // 4b: rearm from GONE, then abort mid-POP
    set_px(0, 18);
    bus.rearm = 1'b1; tick(); bus.rearm = 1'b0; tick();
    check_vec("t4_rearm_gone_rgb", bus.RGBout, C_RIM);
    check_vec("t4_rearm_gone_popping", 8'(bus.popping), 8'd0);
    pulse_pop();
    repeat (3) sof();
    bus.rearm = 1'b1; tick(); bus.rearm = 1'b0;
    check_vec("t4_abort_popping", 8'(bus.popping), 8'd0);
    check_vec("t4_abort_popdone", 8'(bus.popDone), 8'd0);
    tick();
    check_vec("t4_abort_rgb", bus.RGBout, C_RIM);
    pd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bus.startOfFrame = 1'b1;
      tick();
      if (bus.popDone) pd_cnt++;
      bus.startOfFrame = 1'b0;
      tick();
    end
    check_vec("t4_abort_no_done", 8'(pd_cnt), 8'd0);
    check_vec("t4_alive_rgb", bus.RGBout, C_RIM);

    // 5: asynchronous reset in pop frame 2
    pulse_pop();
    repeat (6) sof();
    check_vec("t5_f2_rgb", bus.RGBout, C_F2);
    resetN = 1'b0;
    #1;
    check_vec("t5_rst_rgb", bus.RGBout, C_TR);
    check_vec("t5_rst_req", 8'(bus.drawingRequest), 8'd0);
    check_vec("t5_rst_popping", 8'(bus.popping), 8'd0);
    #3 resetN = 1'b1;
    tick(); tick();
    check_vec("t5_post_rgb", bus.RGBout, C_RIM);
    check_vec("t5_post_popping", 8'(bus.popping), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
